// File: rtl/imem_boot_loader.sv
// Boot loader: streams host words into instruction memory, reads the image back,
// compares checksums and releases the core reset only once the image is verified.
module imem_boot_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [3:0]        mem_masking,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_w_data,
    input  logic              mem_valid,
    input  logic [31:0]       mem_r_data,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    localparam int unsigned     TW          = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] MaxCount    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [TW-1:0]   TimeoutLast = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StWrite, StVerify, StCheck, StDone, StError
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       sum_q, sum_d;
    logic [31:0]       rb_q, rb_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              last_addr;
    logic              access_d;

    // Compare against count-1 so a full-depth load never needs the address to wrap.
    assign last_addr   = ({1'b0, addr_q} == (count_q - 1'b1));
    assign access_d    = (state_d == StWrite) || (state_d == StVerify);
    assign mem_address = addr_q;
    assign mem_w_data  = word_q;
    assign checksum    = sum_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        word_d   = word_q;
        sum_d    = sum_q;
        rb_d     = rb_q;
        tcnt_d   = tcnt_q;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    if (word_count == '0 || word_count > MaxCount) begin
                        state_d = StError;
                    end else begin
                        count_d = word_count;
                        addr_d  = '0;
                        sum_d   = '0;
                        rb_d    = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    sum_d   = sum_q + in_data;
                    tcnt_d  = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (mem_valid) begin
                    tcnt_d = '0;
                    if (last_addr) begin
                        addr_d  = '0;
                        state_d = StVerify;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StFetch;
                    end
                end else if (tcnt_q == TimeoutLast) begin
                    state_d = StError;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StVerify: begin
                if (mem_valid) begin
                    tcnt_d = '0;
                    rb_d   = rb_q + mem_r_data;
                    if (last_addr) begin
                        state_d = StCheck;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else if (tcnt_q == TimeoutLast) begin
                    state_d = StError;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StCheck: begin
                state_d = (rb_q == sum_q) ? StDone : StError;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            addr_q      <= '0;
            word_q      <= '0;
            sum_q       <= '0;
            rb_q        <= '0;
            tcnt_q      <= '0;
            mem_request <= 1'b0;
            mem_we_re   <= 1'b0;
            mem_masking <= 4'h0;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            sum_q       <= sum_d;
            rb_q        <= rb_d;
            tcnt_q      <= tcnt_d;
            mem_request <= access_d;
            mem_we_re   <= (state_d == StWrite);
            mem_masking <= access_d ? 4'hF : 4'h0;
            core_rst    <= (state_d != StDone);
            busy        <= (state_d == StFetch) || (state_d == StWrite) ||
                           (state_d == StVerify) || (state_d == StCheck);
            done        <= (state_d == StDone);
            error       <= (state_d == StError);
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed sequence with random data, a latency-configurable
// memory responder and a reference checksum/image model.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned DEPTH   = 256;

    logic              clk, rst, start, in_valid, in_ready;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       in_data;
    logic              mem_request, mem_we_re, mem_valid;
    logic [3:0]        mem_masking;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_w_data, mem_r_data, checksum;
    logic              core_rst, busy, done, error;

    imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_masking(mem_masking),
        .mem_address(mem_address), .mem_w_data(mem_w_data), .mem_valid(mem_valid),
        .mem_r_data(mem_r_data), .core_rst(core_rst), .busy(busy), .done(done),
        .error(error), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder state and logs
    logic [31:0] mem      [DEPTH];
    int          wr_cnt   [DEPTH];
    int          wr_order [DEPTH];
    int          rd_order [DEPTH];
    int          writes, reads, wait_c;
    int          lat, corrupt_addr, stall_idx;
    logic        mem_clr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid  <= 1'b0;
            mem_r_data <= '0;
            wait_c     <= 0;
        end else if (mem_clr) begin
            mem_valid <= 1'b0;
            wait_c    <= 0;
            writes    <= 0;
            reads     <= 0;
            for (int i = 0; i < DEPTH; i++) wr_cnt[i] <= 0;
        end else begin
            mem_valid <= 1'b0;
            if (mem_request && !mem_valid) begin
                if (mem_we_re && writes == stall_idx) begin
                    wait_c <= 0;
                end else if (wait_c >= lat - 1) begin
                    mem_valid <= 1'b1;
                    wait_c    <= 0;
                    if (mem_we_re) begin
                        mem[mem_address]     <= mem_w_data;
                        wr_cnt[mem_address]  <= wr_cnt[mem_address] + 1;
                        wr_order[writes]     <= int'(mem_address);
                        writes               <= writes + 1;
                    end else begin
                        mem_r_data <= mem[mem_address] ^
                                      ((int'(mem_address) == corrupt_addr) ? 32'd1 : 32'd0);
                        rd_order[reads] <= int'(mem_address);
                        reads           <= reads + 1;
                    end
                end else begin
                    wait_c <= wait_c + 1;
                end
            end else begin
                wait_c <= 0;
            end
        end
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] words [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_sum(input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++) s = s + words[i];
        return s;
    endfunction

    task automatic clear_mem();
        @(negedge clk) mem_clr = 1'b1;
        @(negedge clk) mem_clr = 1'b0;
    endtask

    task automatic start_load(input int n, input bit legal);
        @(negedge clk);
        word_count = (ADDR_W + 1)'(n);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (legal) chk("start_busy", {30'b0, busy, core_rst}, 32'h3);
        else       chk("start_error", {29'b0, error, busy, core_rst}, 32'h5);
    endtask

    // Acts as the host; also checks handshake/hold rules every cycle.
    task automatic drive(input int n, input bit toggle, input int abort_addr,
                         output int addr1_cycles);
        int                idx      = 0;
        bit                finished = 0;
        logic              p_req    = 1'b0;
        logic              p_we     = 1'b0;
        logic              p_val    = 1'b0;
        logic [ADDR_W-1:0] p_addr   = '0;
        logic [31:0]       p_wd     = '0;
        addr1_cycles = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (p_req && !p_val && !error) begin
                chk("hold_req", {30'b0, mem_request, mem_we_re}, {30'b0, 1'b1, p_we});
                chk("hold_addr", 32'(mem_address), 32'(p_addr));
                if (p_we) chk("hold_wdata", mem_w_data, p_wd);
            end
            chk("ready_only_fetch", 32'(in_ready && (!busy || mem_request)), 32'd0);
            chk("core_rst_while_busy", 32'(busy && !core_rst), 32'd0);
            if (mem_request && mem_we_re && mem_address == ADDR_W'(1)) addr1_cycles++;
            if (done || error) begin
                finished = 1;
                break;
            end
            if (abort_addr >= 0 && mem_request && mem_we_re && int'(mem_address) == abort_addr) begin
                finished = 1;
                break;
            end
            p_req    = mem_request;
            p_we     = mem_we_re;
            p_val    = mem_valid;
            p_addr   = mem_address;
            p_wd     = mem_w_data;
            in_valid = (idx < n) && (!toggle || (cyc % 2 == 0));
            in_data  = (idx < n) ? words[idx] : 32'd0;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("load_finished", 32'(finished), 32'd1);
    endtask

    task automatic check_done(input int n);
        chk("done_flags", {28'b0, done, error, busy, core_rst}, 32'h8);
        chk("done_checksum", checksum, ref_sum(n));
        chk("done_idle_mem", {27'b0, mem_request, mem_masking}, 32'd0);
        chk("write_count", 32'(writes), 32'(n));
        chk("read_count", 32'(reads), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk("image_word", mem[i], words[i]);
            chk("write_once", 32'(wr_cnt[i]), 32'd1);
            chk("write_order", 32'(wr_order[i]), 32'(i));
            chk("read_order", 32'(rd_order[i]), 32'(i));
        end
    endtask

    int c;

    initial begin
        rst = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
        mem_clr = 1'b0; lat = 1; corrupt_addr = -1; stall_idx = -1;
        writes = 0; reads = 0;
        #1;
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_flags", {26'b0, busy, done, error, mem_request, mem_we_re, in_ready}, 32'd0);
        chk("rst_mem_bus", {4'b0, mem_masking, 16'(mem_address), 8'b0}, 32'd0);
        chk("rst_wdata", mem_w_data, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed program, memory answering one cycle after request
        words[0] = 32'h00500093; words[1] = 32'h00A00113;
        words[2] = 32'h002081B3; words[3] = 32'h0000006F;
        clear_mem();
        start_load(4, 1);
        drive(4, 0, -1, c);
        check_done(4);
        chk("prog_checksum", checksum, 32'h011083C8);

        // Same image, throttled host and slow memory; restarts out of DONE
        lat = 3;
        clear_mem();
        start_load(4, 1);
        drive(4, 1, -1, c);
        check_done(4);

        // Corrupted readback at address 2
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        lat = 2; corrupt_addr = 2;
        clear_mem();
        start_load(5, 1);
        drive(5, 0, -1, c);
        chk("corrupt_flags", {28'b0, done, error, busy, core_rst}, 32'h5);
        chk("corrupt_checksum", checksum, ref_sum(5));
        corrupt_addr = -1;

        // Memory never answers the second write
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        lat = 1; stall_idx = 1;
        clear_mem();
        start_load(3, 1);
        drive(3, 0, -1, c);
        chk("timeout_cycles", 32'(c), 32'(TIMEOUT));
        chk("timeout_flags", {29'b0, error, mem_request, core_rst}, 32'h5);
        stall_idx = -1;
        words[0] = $urandom;
        clear_mem();
        start_load(1, 1);
        drive(1, 0, -1, c);
        check_done(1);

        // Illegal counts
        start_load(0, 0);
        start_load(300, 0);
        start_load(257, 0);

        // Full depth, incrementing data
        for (int i = 0; i < DEPTH; i++) words[i] = 32'(i);
        lat = 1;
        clear_mem();
        start_load(256, 1);
        drive(256, 0, -1, c);
        check_done(256);
        chk("full_checksum", checksum, 32'd32640);

        // Reset while writing word 1
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        lat = 3;
        clear_mem();
        start_load(3, 1);
        drive(3, 0, 1, c);
        rst = 1'b1;
        #1;
        chk("abort_core_rst", 32'(core_rst), 32'd1);
        chk("abort_flags", {26'b0, busy, done, error, mem_request, mem_we_re, in_ready}, 32'd0);
        chk("abort_masking", 32'(mem_masking), 32'd0);
        chk("abort_checksum", checksum, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        clear_mem();
        start_load(4, 1);
        drive(4, 0, -1, c);
        check_done(4);

        // Random lengths, latencies and host throttling
        for (int t = 0; t < 4; t++) begin
            int n;
            n   = int'($urandom_range(1, 20));
            lat = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) words[i] = $urandom;
            clear_mem();
            start_load(n, 1);
            drive(n, 1'($urandom_range(0, 1)), -1, c);
            check_done(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
